pair_batch_scheduler: RTL and testbench

PAIR_BATCH_SCHEDULER -- requirements
Module: pair_batch_scheduler

---
 rtl/pair_batch_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_pair_batch_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pair_batch_scheduler.sv
// Enumerates every unordered point pair (u,v), u < v < N, and hands them to a
// distance datapath in batches of BATCH_SIZE lanes that share one reference point u.
module pair_batch_scheduler #(
    parameter int INDEX_BIT_WIDTH = 16,
    parameter int COORD_BIT_WIDTH = 12,
    parameter int DIMENSIONS      = 3,
    parameter int BATCH_SIZE      = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic [INDEX_BIT_WIDTH-1:0]                       num_points,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             mem_rd_en,
    output logic [INDEX_BIT_WIDTH-1:0]                       mem_rd_addr,
    input  logic [DIMENSIONS*COORD_BIT_WIDTH-1:0]            mem_rd_data,
    output logic [DIMENSIONS*COORD_BIT_WIDTH-1:0]            reference_point,
    output logic [INDEX_BIT_WIDTH-1:0]                       reference_index,
    output logic [BATCH_SIZE*DIMENSIONS*COORD_BIT_WIDTH-1:0] coords,
    output logic [BATCH_SIZE*INDEX_BIT_WIDTH-1:0]            in_indices,
    output logic [BATCH_SIZE-1:0]                            lane_valid,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [2*INDEX_BIT_WIDTH-1:0]                     pair_count
);

    localparam int POINT_W = DIMENSIONS * COORD_BIT_WIDTH;
    localparam int CNT_W   = $clog2(BATCH_SIZE + 1);
    localparam logic [CNT_W-1:0]           LANES   = CNT_W'(BATCH_SIZE);
    localparam logic [INDEX_BIT_WIDTH-1:0] MIN_PTS = INDEX_BIT_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        REF_RD,
        REF_CAP,
        FILL,
        EMIT,
        FIN
    } state_t;

    state_t                     state;
    logic [INDEX_BIT_WIDTH-1:0] n_reg;
    logic [INDEX_BIT_WIDTH-1:0] u_reg;
    logic [INDEX_BIT_WIDTH-1:0] next_v;
    logic [INDEX_BIT_WIDTH-1:0] pend_addr;
    logic                       pend;
    logic [CNT_W-1:0]           fill_cnt;
    logic [CNT_W-1:0]           issued_cnt;

    logic can_issue;
    logic last_return;
    logic batch_full;
    logic more_for_u;
    logic more_refs;

    // A read issued in cycle t returns in t+1; pend/pend_addr track that return.
    assign can_issue   = (issued_cnt < LANES) && (next_v < n_reg);
    assign last_return = (pend_addr == n_reg - 1'b1);
    assign batch_full  = (fill_cnt + 1'b1 == LANES);
    assign more_for_u  = (next_v < n_reg);
    assign more_refs   = (u_reg + 1'b1) < (n_reg - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the lane and reference registers are reset as well, because
            // they are outputs that must read 0 after reset, not just internal state.
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_rd_addr     <= '0;
            reference_point <= '0;
            reference_index <= '0;
            coords          <= '0;
            in_indices      <= '0;
            lane_valid      <= '0;
            out_valid       <= 1'b0;
            pair_count      <= '0;
            n_reg           <= '0;
            u_reg           <= '0;
            next_v          <= '0;
            pend_addr       <= '0;
            pend            <= 1'b0;
            fill_cnt        <= '0;
            issued_cnt      <= '0;
        end else begin
            // NOTE: every state register uses <= so all decisions below see the
            // values from before this edge, regardless of statement order.
            done      <= 1'b0;
            pend      <= mem_rd_en;
            pend_addr <= mem_rd_addr;

            case (state)
                IDLE: begin
                    mem_rd_en <= 1'b0;
                    if (start) begin
                        busy       <= 1'b1;
                        pair_count <= '0;
                        n_reg      <= num_points;
                        u_reg      <= '0;
                        if (num_points < MIN_PTS) begin
                            state <= FIN;
                        end else begin
                            state       <= REF_RD;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= '0;
                        end
                    end
                end

                REF_RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= REF_CAP;
                end

                REF_CAP: begin
                    reference_point <= mem_rd_data;
                    reference_index <= u_reg;
                    mem_rd_en       <= 1'b1;
                    mem_rd_addr     <= u_reg + 1'b1;
                    next_v          <= u_reg + INDEX_BIT_WIDTH'(2);
                    issued_cnt      <= CNT_W'(1);
                    fill_cnt        <= '0;
                    state           <= FILL;
                end

                FILL: begin
                    if (pend) begin
                        for (int i = 0; i < BATCH_SIZE; i++) begin
                            if (CNT_W'(i) == fill_cnt) begin
                                coords[i*POINT_W +: POINT_W]                 <= mem_rd_data;
                                in_indices[i*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH] <= pend_addr;
                                lane_valid[i]                                <= 1'b1;
                            end
                        end
                        fill_cnt <= fill_cnt + 1'b1;
                        if (batch_full || last_return) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                        end
                    end
                    if (can_issue) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= next_v;
                        next_v      <= next_v + 1'b1;
                        issued_cnt  <= issued_cnt + 1'b1;
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                end

                EMIT: begin
                    mem_rd_en <= 1'b0;
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        pair_count <= pair_count + (2*INDEX_BIT_WIDTH)'(fill_cnt);
                        coords     <= '0;
                        in_indices <= '0;
                        lane_valid <= '0;
                        fill_cnt   <= '0;
                        if (more_for_u) begin
                            state       <= FILL;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= next_v;
                            next_v      <= next_v + 1'b1;
                            issued_cnt  <= CNT_W'(1);
                        end else if (more_refs) begin
                            state       <= REF_RD;
                            u_reg       <= u_reg + 1'b1;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= u_reg + 1'b1;
                        end else begin
                            state <= FIN;
                        end
                    end
                end

                FIN: begin
                    mem_rd_en <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pair_batch_scheduler.sv
// Randomized bench for pair_batch_scheduler: a behavioural memory plus a queue of
// expected batches derived directly from the pair enumeration order.
module tb_pair_batch_scheduler;

    localparam int W  = 16;
    localparam int C  = 12;
    localparam int D  = 3;
    localparam int B  = 4;
    localparam int PW = D * C;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [W-1:0]      num_points;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [W-1:0]      mem_rd_addr;
    logic [PW-1:0]     mem_rd_data;
    logic [PW-1:0]     reference_point;
    logic [W-1:0]      reference_index;
    logic [B*PW-1:0]   coords;
    logic [B*W-1:0]    in_indices;
    logic [B-1:0]      lane_valid;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    pair_count;

    pair_batch_scheduler #(
        .INDEX_BIT_WIDTH(W),
        .COORD_BIT_WIDTH(C),
        .DIMENSIONS     (D),
        .BATCH_SIZE     (B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_points     (num_points),
        .busy           (busy),
        .done           (done),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .reference_point(reference_point),
        .reference_index(reference_index),
        .coords         (coords),
        .in_indices     (in_indices),
        .lane_valid     (lane_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pair_count     (pair_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              u;
        logic [B*W-1:0]  idx;
        logic [B*PW-1:0] crd;
        logic [B-1:0]    mask;
    } batch_t;

    logic [PW-1:0] mem [0:63];
    batch_t        exp_q[$];
    batch_t        head;
    int            vectors = 0;
    int            errors  = 0;
    bit            mon_en  = 1'b0;
    int            ready_mode = 0;
    int            stall_left = 0;
    int            cur_n = 0;

    // Memory returns data one cycle after the strobe; junk otherwise.
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? mem[mem_rd_addr[5:0]] : PW'($urandom);

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (mem_rd_en)
                check("rd_addr_range", 160'(int'(mem_rd_addr) < cur_n), 160'(1));
            if (out_valid) begin
                check("rd_during_emit", 160'(mem_rd_en), 160'(0));
                check("unexpected_batch", 160'(exp_q.size() == 0), 160'(0));
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    check("reference_index", 160'(reference_index), 160'(head.u));
                    check("reference_point", 160'(reference_point), 160'(mem[head.u]));
                    check("lane_valid", 160'(lane_valid), 160'(head.mask));
                    check("in_indices", 160'(in_indices), 160'(head.idx));
                    check("coords", 160'(coords), 160'(head.crd));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic build_model(input int n);
        exp_q.delete();
        for (int u = 0; u + 1 < n; u++) begin
            for (int vs = u + 1; vs < n; vs += B) begin
                batch_t b;
                b.u    = u;
                b.idx  = '0;
                b.crd  = '0;
                b.mask = '0;
                for (int k = 0; k < B && vs + k < n; k++) begin
                    b.idx[k*W +: W]   = W'(vs + k);
                    b.crd[k*PW +: PW] = mem[vs + k];
                    b.mask[k]         = 1'b1;
                end
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic run(input int n, input int mode, input bit glitch);
        int cyc;
        int pairs;
        pairs = n * (n - 1) / 2;
        for (int i = 0; i < 64; i++) mem[i] = PW'({$urandom, $urandom});
        build_model(n);
        cur_n      = n;
        ready_mode = mode;
        stall_left = 5;
        @(negedge clk);
        num_points = W'(n);
        start      = 1'b1;
        mon_en     = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        num_points = W'($urandom);
        check("busy_after_start", 160'(busy), 160'(1));
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = glitch && (cyc == 3 || cyc == 9);
        end
        start = 1'b0;
        check("done_seen", 160'(done), 160'(1));
        check("busy_at_done", 160'(busy), 160'(0));
        check("pair_count", 160'(pair_count), 160'(pairs));
        check("batches_left", 160'(exp_q.size()), 160'(0));
        if (n < 2) check("done_latency", 160'(cyc), 160'(2));
        mon_en = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 160'(done), 160'(0));
        check("pair_count_hold", 160'(pair_count), 160'(pairs));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 160'(busy), 160'(0));
        check({tag, "_done"}, 160'(done), 160'(0));
        check({tag, "_out_valid"}, 160'(out_valid), 160'(0));
        check({tag, "_mem_rd_en"}, 160'(mem_rd_en), 160'(0));
        check({tag, "_lane_valid"}, 160'(lane_valid), 160'(0));
        check({tag, "_pair_count"}, 160'(pair_count), 160'(0));
        check({tag, "_reference_point"}, 160'(reference_point), 160'(0));
        check({tag, "_reference_index"}, 160'(reference_index), 160'(0));
        check({tag, "_coords"}, 160'(coords), 160'(0));
        check({tag, "_in_indices"}, 160'(in_indices), 160'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_points = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        run(4, 0, 1'b0);
        run(6, 0, 1'b0);
        run(5, 2, 1'b0);
        run(0, 0, 1'b0);
        run(1, 0, 1'b0);
        run(2, 1, 1'b0);
        run(9, 1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(2, 12));
            run(n, int'($urandom_range(0, 2)), n >= 4);
        end

        // Reset while the first batch is still being filled.
        for (int i = 0; i < 64; i++) mem[i] = PW'({$urandom, $urandom});
        exp_q.delete();
        @(negedge clk);
        num_points = W'(10);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("fill_reading", 160'(mem_rd_en), 160'(1));
        rst = 1'b1;
        @(negedge clk);
        check_cleared("mid_run_reset");
        rst = 1'b0;
        run(5, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
